// File: rtl/rd_arb_pkg.sv
// Shared types for the read-port arbiter: requester tag and credit-counter widths.
package rd_arb_pkg;
  localparam int MAX_REQ = 8;
  localparam int MAX_CRD = 64;

  // Sized for the largest supported requester count so one tag type serves every configuration.
  typedef logic [$clog2(MAX_REQ)-1:0]   req_idx_t;
  typedef logic [$clog2(MAX_CRD+1)-1:0] crd_t;

  function automatic int crd_w(input int credits);
    return $clog2(credits + 1);
  endfunction
endpackage

// File: rtl/rd_tag_fifo.sv
// In-order tag FIFO: records which requester owns each outstanding memory read.
module rd_tag_fifo
  import rd_arb_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     aclk,
  input  logic     aresetn,
  input  logic     push,
  input  req_idx_t din,
  input  logic     pop,
  output req_idx_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(DEPTH);

  req_idx_t      mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rp];

  always_ff @(posedge aclk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/rd_port_rr_arbiter.sv
// Round-robin, credit-gated sharing of one in-order memory read port among N_REQ requesters.
module rd_port_rr_arbiter
  import rd_arb_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int ADDR_W    = 8,
  parameter  int DATA_W    = 16,
  parameter  int CREDITS   = 16,
  parameter  int MAX_OUTST = 8,
  localparam int CW        = crd_w(CREDITS)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_read,
  input  logic [DATA_W-1:0]       mem_data,
  input  logic                    mem_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        crd_ret,
  output logic [N_REQ*CW-1:0]     crd_cnt,
  output logic                    err
);
  logic [N_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [CW-1:0]                cnt_q [N_REQ];
  logic [N_REQ-1:0]             elig, gnt, crd_ovf, rsp_nxt;
  req_idx_t                     rr_ptr, gnt_idx, tag_out;
  logic                         tag_full, tag_empty, push, pop, found, err_q;

  assign addr_a    = req_addr;
  assign push      = |gnt;
  assign pop       = mem_valid & ~tag_empty;
  assign req_ready = gnt;
  assign mem_read  = push;
  assign err       = err_q;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign elig[i]    = req_valid[i] & (cnt_q[i] != '0) & ~tag_full;
    assign crd_ovf[i] = crd_ret[i] & ~gnt[i] & (cnt_q[i] == CW'(CREDITS));
    assign rsp_nxt[i] = pop & (tag_out == req_idx_t'(i));
    assign crd_cnt[i*CW +: CW] = cnt_q[i];

    // A return coinciding with a grant cancels out; returns past CREDITS saturate.
    always_ff @(posedge aclk) begin
      if (!aresetn)
        cnt_q[i] <= CW'(CREDITS);
      else if (gnt[i] && !crd_ret[i])
        cnt_q[i] <= cnt_q[i] - CW'(1);
      else if (crd_ret[i] && !gnt[i] && cnt_q[i] != CW'(CREDITS))
        cnt_q[i] <= cnt_q[i] + CW'(1);
    end
  end

  // Scan starting at rr_ptr; first eligible requester wins.
  always_comb begin
    int j;
    j        = 0;
    found    = 1'b0;
    gnt      = '0;
    gnt_idx  = '0;
    mem_addr = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rr_ptr) + k) % N_REQ;
      if (!found && elig[j]) begin
        found    = 1'b1;
        gnt[j]   = 1'b1;
        gnt_idx  = req_idx_t'(j);
        mem_addr = addr_a[j];
      end
    end
  end

  rd_tag_fifo #(.DEPTH(MAX_OUTST)) u_tag (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .din     (gnt_idx),
    .pop     (pop),
    .dout    (tag_out),
    .full    (tag_full),
    .empty   (tag_empty)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rr_ptr    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      err_q     <= 1'b0;
    end else begin
      if (push)
        rr_ptr <= (gnt_idx == req_idx_t'(N_REQ-1)) ? '0 : gnt_idx + req_idx_t'(1);
      rsp_valid <= rsp_nxt;
      if (pop) rsp_data <= mem_data;
      if (|crd_ovf || (mem_valid && tag_empty)) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rd_port_rr_arbiter.sv
// Directed bench for rd_port_rr_arbiter: grant table plus multi-cycle corner sequences.
module tb_rd_port_rr_arbiter;
  localparam int N_REQ = 4, ADDR_W = 8, DATA_W = 16, CREDITS = 16, MAX_OUTST = 8;
  localparam int CW = $clog2(CREDITS + 1);

  logic                    aclk = 1'b0;
  logic                    aresetn = 1'b0;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_valid = '0, req_ready, rsp_valid, crd_ret = '0;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_read, err;
  logic                    mem_valid = 1'b0;
  logic [DATA_W-1:0]       mem_data = '0, rsp_data;
  logic [N_REQ*CW-1:0]     crd_cnt;

  int checks = 0, errors = 0;
  bit mem_auto;
  logic p0_v, p1_v;
  logic [DATA_W-1:0] p0_d, p1_d;
  int exp_q[$];

  typedef struct { logic [N_REQ-1:0] rv; int g; } vec_t;
  vec_t tbl [13];

  always #5 aclk = ~aclk;

  rd_port_rr_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                       .CREDITS(CREDITS), .MAX_OUTST(MAX_OUTST)) dut (
    .aclk(aclk), .aresetn(aresetn), .req_addr(req_addr), .req_valid(req_valid),
    .req_ready(req_ready), .mem_addr(mem_addr), .mem_read(mem_read),
    .mem_data(mem_data), .mem_valid(mem_valid), .rsp_data(rsp_data),
    .rsp_valid(rsp_valid), .crd_ret(crd_ret), .crd_cnt(crd_cnt), .err(err)
  );

  function automatic logic [DATA_W-1:0] dat(input int i);
    logic [7:0] a;
    a = 8'h10 + 8'(i);
    return {8'hD0, a};
  endfunction

  function automatic int cnt(input int i);
    return int'(crd_cnt[i*CW +: CW]);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock: check the expected grant, advance, check the response, run the memory model.
  task automatic step(input int g);
    logic iss, mv;
    logic [ADDR_W-1:0] ia;
    logic [N_REQ-1:0] eg;
    int e;
    #1;
    eg = '0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      exp_q.push_back(g);
      chk("mem_addr", 32'(mem_addr), 32'(dat(g) & 16'h00FF));
    end
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("mem_read", 32'(mem_read), 32'(g >= 0));
    iss = mem_read; ia = mem_addr; mv = mem_valid;
    @(posedge aclk); #1;
    if (mv && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(1 << e));
      chk("rsp_data", 32'(rsp_data), 32'(dat(e)));
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'h0);
    end
    if (mem_auto) begin
      mem_valid = p1_v; mem_data = p1_d;
      p1_v = p0_v; p1_d = p0_d;
      p0_v = iss; p0_d = {8'hD0, ia};
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0; mem_valid = 1'b0; crd_ret = '0; exp_q.delete();
    p0_v = 1'b0; p1_v = 1'b0; mem_auto = 1'b1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = 8'h10 + 8'(i);
    tbl[0]  = '{4'b1111, 0}; tbl[1]  = '{4'b1111, 1}; tbl[2]  = '{4'b1111, 2};
    tbl[3]  = '{4'b1111, 3}; tbl[4]  = '{4'b1111, 0}; tbl[5]  = '{4'b1010, 1};
    tbl[6]  = '{4'b1010, 3}; tbl[7]  = '{4'b0101, 0}; tbl[8]  = '{4'b0101, 2};
    tbl[9]  = '{4'b0000, -1}; tbl[10] = '{4'b0011, 0}; tbl[11] = '{4'b1001, 3};
    tbl[12] = '{4'b1001, 0};

    // Reset state and round-robin table with 2-cycle memory latency
    do_reset();
    for (int i = 0; i < N_REQ; i++) chk("rst_cnt", 32'(cnt(i)), 32'(CREDITS));
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    foreach (tbl[v]) begin
      req_valid = tbl[v].rv;
      step(tbl[v].g);
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) step(-1);
    chk("drain", 32'(exp_q.size()), 32'h0);

    // Credit exhaustion on a single requester, then one returned credit
    do_reset();
    req_valid = 4'b0100;
    for (int k = 0; k < CREDITS; k++) step(2);
    step(-1);
    chk("cnt2_empty", 32'(cnt(2)), 32'h0);
    crd_ret = 4'b0100;
    step(-1);
    crd_ret = '0;
    step(2);
    step(-1);
    chk("cnt2_after_ret", 32'(cnt(2)), 32'h0);
    req_valid = '0;
    for (int k = 0; k < 4; k++) step(-1);

    // Tag FIFO full with memory stalled; one response frees exactly one slot
    do_reset();
    mem_auto = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < MAX_OUTST; k++) step(k % N_REQ);
    step(-1);
    step(-1);
    mem_valid = 1'b1; mem_data = dat(0);
    step(-1);
    mem_valid = 1'b0;
    step(0);
    step(-1);

    // Credit return coinciding with a grant
    do_reset();
    req_valid = 4'b0010;
    for (int k = 0; k < CREDITS - 5; k++) step(1);
    chk("cnt1_pre", 32'(cnt(1)), 32'd5);
    crd_ret = 4'b0010;
    step(1);
    crd_ret = '0;
    chk("cnt1_ret_gnt", 32'(cnt(1)), 32'd5);
    req_valid = '0;
    crd_ret = 4'b0010;
    step(-1);
    crd_ret = '0;
    chk("cnt1_ret_only", 32'(cnt(1)), 32'd6);
    chk("err_clean", 32'(err), 32'h0);

    // Protocol errors: orphan response, credit overflow
    do_reset();
    mem_auto = 1'b0;
    mem_valid = 1'b1; mem_data = 16'hBEEF;
    step(-1);
    mem_valid = 1'b0;
    chk("err_orphan", 32'(err), 32'h1);
    step(-1);
    chk("err_sticky", 32'(err), 32'h1);
    do_reset();
    chk("err_rst", 32'(err), 32'h0);
    crd_ret = 4'b0001;
    step(-1);
    crd_ret = '0;
    chk("err_ovf", 32'(err), 32'h1);
    chk("cnt0_sat", 32'(cnt(0)), 32'(CREDITS));

    // Reset with reads in flight
    do_reset();
    mem_auto = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) step(k % N_REQ);
    do_reset();
    mem_auto = 1'b0;
    for (int i = 0; i < N_REQ; i++) chk("rst2_cnt", 32'(cnt(i)), 32'(CREDITS));
    chk("rst2_err", 32'(err), 32'h0);
    chk("rst2_rsp", 32'(rsp_valid), 32'h0);
    for (int k = 0; k < MAX_OUTST; k++) step(k % N_REQ);
    step(-1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
